// File: rtl/random_pulse_monitor.sv
`default_nettype none
// ============================================================================
// Module   : random_pulse_monitor
// Brief    : Per-window ones density, longest run and stuck detection of a
//            sampled pulse stream, published through a valid/ack interface.
// Revision : 1.0  initial release
// ============================================================================
module random_pulse_monitor #(
    parameter int WINDOW      = 256,
    parameter int MIN_PULSES  = 32,
    parameter int MAX_PULSES  = 224,
    parameter int STUCK_LIMIT = 64,
    localparam int CW         = $clog2(WINDOW + 1),
    localparam int RW         = $clog2(STUCK_LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          q_in,
    input  logic          clear,
    input  logic          result_ack,
    output logic          result_valid,
    output logic [CW-1:0] pulse_count,
    output logic [RW-1:0] max_run,
    output logic          pass,
    output logic          fail_low,
    output logic          fail_high,
    output logic          stuck_alarm,
    output logic          overrun
);

    localparam logic [CW-1:0] c_window = CW'(WINDOW);
    localparam logic [CW-1:0] c_min    = CW'(MIN_PULSES);
    localparam logic [CW-1:0] c_max    = CW'(MAX_PULSES);
    localparam logic [RW-1:0] c_stuck  = RW'(STUCK_LIMIT);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   sample_idx_q, sample_idx_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [RW-1:0]   run_q, run_d;
    logic [RW-1:0]   win_max_q, win_max_d;
    logic            prev_q, prev_d;
    logic            result_valid_q, result_valid_d;
    logic [CW-1:0]   pulse_count_q, pulse_count_d;
    logic [RW-1:0]   max_run_q, max_run_d;
    logic            pass_q, pass_d;
    logic            fail_low_q, fail_low_d;
    logic            fail_high_q, fail_high_d;
    logic            stuck_q, stuck_d;
    logic            overrun_q, overrun_d;

    logic [RW-1:0]   w_run_next;
    logic [RW-1:0]   w_wmax_next;
    logic [CW-1:0]   w_acc_next;
    logic [CW-1:0]   w_idx_inc;
    logic            w_win_first;
    logic            w_done;

    always_comb begin
        // The run only restarts on a value change or on the very first sample
        // after reset/clear; window boundaries deliberately do not break it.
        if (state_q == IDLE || q_in != prev_q) begin
            w_run_next = RW'(1);
        end else if (run_q == c_stuck) begin
            w_run_next = run_q;
        end else begin
            w_run_next = run_q + RW'(1);
        end

        w_win_first = (sample_idx_q == '0);
        w_acc_next  = (w_win_first ? '0 : acc_q) + CW'(q_in);
        w_wmax_next = (w_win_first || w_run_next > win_max_q) ? w_run_next : win_max_q;
        w_idx_inc   = sample_idx_q + CW'(1);
        w_done      = ce && (w_idx_inc == c_window);

        state_d        = state_q;
        sample_idx_d   = sample_idx_q;
        acc_d          = acc_q;
        run_d          = run_q;
        win_max_d      = win_max_q;
        prev_d         = prev_q;
        result_valid_d = result_valid_q;
        pulse_count_d  = pulse_count_q;
        max_run_d      = max_run_q;
        pass_d         = pass_q;
        fail_low_d     = fail_low_q;
        fail_high_d    = fail_high_q;
        stuck_d        = stuck_q;
        overrun_d      = overrun_q;

        if (clear) begin
            state_d        = IDLE;
            sample_idx_d   = '0;
            acc_d          = '0;
            run_d          = '0;
            win_max_d      = '0;
            prev_d         = 1'b0;
            result_valid_d = 1'b0;
            pulse_count_d  = '0;
            max_run_d      = '0;
            pass_d         = 1'b0;
            fail_low_d     = 1'b0;
            fail_high_d    = 1'b0;
            stuck_d        = 1'b0;
            overrun_d      = 1'b0;
        end else begin
            if (ce) begin
                state_d      = MEASURE;
                prev_d       = q_in;
                run_d        = w_run_next;
                acc_d        = w_acc_next;
                win_max_d    = w_wmax_next;
                sample_idx_d = w_done ? '0 : w_idx_inc;
                if (w_run_next == c_stuck) begin
                    stuck_d = 1'b1;
                end
            end

            // A completing window takes precedence over an ack in the same cycle.
            if (w_done) begin
                result_valid_d = 1'b1;
                pulse_count_d  = w_acc_next;
                max_run_d      = w_wmax_next;
                fail_low_d     = (w_acc_next < c_min);
                fail_high_d    = (w_acc_next > c_max);
                pass_d         = (w_acc_next >= c_min) && (w_acc_next <= c_max);
                if (result_valid_q && !result_ack) begin
                    overrun_d = 1'b1;
                end
            end else if (result_ack && result_valid_q) begin
                result_valid_d = 1'b0;
                pass_d         = 1'b0;
                fail_low_d     = 1'b0;
                fail_high_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            sample_idx_q   <= '0;
            acc_q          <= '0;
            run_q          <= '0;
            win_max_q      <= '0;
            prev_q         <= 1'b0;
            result_valid_q <= 1'b0;
            pulse_count_q  <= '0;
            max_run_q      <= '0;
            pass_q         <= 1'b0;
            fail_low_q     <= 1'b0;
            fail_high_q    <= 1'b0;
            stuck_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            sample_idx_q   <= sample_idx_d;
            acc_q          <= acc_d;
            run_q          <= run_d;
            win_max_q      <= win_max_d;
            prev_q         <= prev_d;
            result_valid_q <= result_valid_d;
            pulse_count_q  <= pulse_count_d;
            max_run_q      <= max_run_d;
            pass_q         <= pass_d;
            fail_low_q     <= fail_low_d;
            fail_high_q    <= fail_high_d;
            stuck_q        <= stuck_d;
            overrun_q      <= overrun_d;
        end
    end

    assign result_valid = result_valid_q;
    assign pulse_count  = pulse_count_q;
    assign max_run      = max_run_q;
    assign pass         = pass_q;
    assign fail_low     = fail_low_q;
    assign fail_high    = fail_high_q;
    assign stuck_alarm  = stuck_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: doc/random_pulse_monitor.md
Name: random_pulse_monitor

Overview:
- Receive-side companion to the random pulse generator.
- Samples the generator's q stream on the same clock-enable and measures each fixed window of samples:
  - pulse count (ones density);
  - longest run of identical samples;
  - stuck-at detection.
- Publishes per-window results through a valid/ack register interface.
- Sits beside the generator in the hardware test harness and flags a degenerate or biased pulse source.

Parameters:
- WINDOW, 256, sampled cycles (ce=1) per measurement window; >=2.
- MIN_PULSES, 32, minimum ones per window for pass.
- MAX_PULSES, 224, maximum ones per window for pass; MIN_PULSES<=MAX_PULSES<=WINDOW.
- STUCK_LIMIT, 64, run length that raises the stuck alarm; run counters saturate here.
- Derived: CW=$clog2(WINDOW+1), RW=$clog2(STUCK_LIMIT+1).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-low reset (0 = reset).
- ce, input, 1, sample enable; same enable that drives the generator.
- q_in, input, 1, pulse stream from the generator.
- clear, input, 1, synchronous restart: aborts window, clears results and sticky flags.
- result_ack, input, 1, consumer accepts current result.
- result_valid, output, 1, result registers hold an unconsumed window result.
- pulse_count, output, CW, ones counted in the last completed window.
- max_run, output, RW, longest same-value run seen in that window (saturated).
- pass, output, 1, MIN_PULSES<=pulse_count<=MAX_PULSES.
- fail_low, output, 1, pulse_count<MIN_PULSES.
- fail_high, output, 1, pulse_count>MAX_PULSES.
- stuck_alarm, output, 1, sticky; set when the run counter reaches STUCK_LIMIT.
- overrun, output, 1, sticky; a window completed while result_valid=1 and not acked.

Behaviour:
- Reset (rst=0, async) or clear=1 (sync, highest priority after reset):
  - all outputs and internal counters go to 0;
  - FSM enters IDLE.
- FSM states:
  - IDLE: wait for first ce=1.
    - On that cycle the sample is taken, sample_idx=1, and the FSM moves to MEASURE.
  - MEASURE: each ce=1 cycle samples q_in. ce=0 cycles are ignored entirely; no counter moves.
- Window counter sample_idx counts 1..WINDOW. On the WINDOW-th sample:
  - results register on the next clock edge, i.e. result latency is 1 clk after the final sample edge;
  - sample_idx wraps to 0;
  - pulse accumulator restarts;
  - the next ce begins a new window with no gap.
- Pulse accumulator is CW bits wide and includes the final sample, so pulse_count ranges 0..WINDOW.
- Run counter:
  - On each sample: if q_in equals the previous sample, run = min(run+1, STUCK_LIMIT); else run = 1.
  - The first sample after reset or clear gives run = 1.
  - The run counter is NOT reset at window boundaries, so stuck detection spans windows.
- Window max: per-window max of run values, including the final sample. It resets to the current sample's run value at the first sample of each window.
- stuck_alarm: sets on the sample where run becomes STUCK_LIMIT; stays set until reset or clear.
- Classification is computed from the final count. Exactly one of pass, fail_low, fail_high is 1 while result_valid=1; all three are 0 while result_valid=0.
- Handshake:
  - result_valid rises with the result load.
  - result_ack while result_valid=1 clears result_valid and the classification bits on the next edge. pulse_count and max_run hold their values.
  - result_ack while result_valid=0 is ignored.
- Completion while result_valid=1 with no ack that cycle: results overwrite with the newest window, result_valid stays 1, overrun sets (sticky).
- Completion in the same cycle as result_ack: new results load, result_valid stays 1, no overrun.
- clear mid-window discards the partial window; no result is produced.
- Reset mid-window behaves the same as clear.

Test Plan:
- q_in=1 constant, ce=1, 256 samples, ack idle → result_valid 1 clk after the 256th sample:
  - pulse_count=256, fail_high=1, max_run=64;
  - stuck_alarm set on the 64th sample.
- q_in alternating 1,0,… for 256 samples → pulse_count=128, pass=1, max_run=1, stuck_alarm=0.
- ce high every other clk with alternating data → window completes after 512 clks; identical results to the previous test; no sample is counted on ce=0 cycles.
- Two windows (first with 16 ones, second with 128 ones), never acked → after the second window: pulse_count=128, pass=1, overrun=1, result_valid=1.
- result_ack asserted exactly on the completion cycle of the next window → result_valid stays 1 with the new values, overrun=0. A later ack with no completion drops result_valid next clk.
- clear (or rst=0) after 100 samples of all-ones → all outputs 0 immediately (rst) or next edge (clear). The following 256 alternating samples give pulse_count=128, pass=1, stuck_alarm=0.
